// File: rtl/ring_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement chain.
//   state_t   : averager FSM states (ACCUM collects samples, HOLD presents a result)
//   COUNT_W   : native width of a ring count
//   acc_width : accumulator width needed to sum 2^log2_samples counts without overflow
package ring_meas_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int COUNT_W = 16;

  function automatic int acc_width(input int width, input int log2_samples);
    return width + log2_samples;
  endfunction

endpackage

// File: rtl/ring_count_averager_min_max_tracker.sv
// Running minimum / maximum of the samples of one batch.
//   clk, rst  : clock and synchronous active-high reset
//   clear     : restart tracking (min = all ones, max = 0); wins over sample
//   sample    : value is part of the current batch
//   value     : sample value
//   min_next  : running min including value when sample=1 (combinational)
//   max_next  : running max including value when sample=1 (combinational)
module min_max_tracker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] min_next,
  output logic [WIDTH-1:0] max_next
);

  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  // The next values are exported so the closing sample of a batch is
  // folded into the reported min/max in the same cycle it arrives.
  always_comb begin
    min_next = min_q;
    max_next = max_q;
    if (sample) begin
      if (value < min_q) min_next = value;
      if (value > max_q) max_next = value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_next;
      max_q <= max_next;
    end
  end

endmodule

// File: rtl/ring_count_averager.sv
// Averages 2^LOG2_SAMPLES consecutive ring counts and presents the truncated
// mean plus batch min/max on a valid/ready port. Samples arriving while a
// result is stalled are dropped and flagged by the sticky overrun bit.
//   clk, rst     : clock and synchronous active-high reset
//   count_in     : ring count, sampled when count_valid=1
//   count_valid  : one-cycle strobe per measurement window
//   avg_out      : floor(sum / 2^LOG2_SAMPLES)
//   min_out      : smallest sample of the batch
//   max_out      : largest sample of the batch
//   avg_valid    : result available, held until avg_ready
//   avg_ready    : consumer accepts the result
//   overrun      : sticky, a sample was dropped while the result was stalled
module ring_count_averager
  import ring_meas_pkg::*;
#(
  parameter int LOG2_SAMPLES = 4,
  parameter int WIDTH        = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             overrun
);

  localparam int ACC_W = acc_width(WIDTH, LOG2_SAMPLES);

  state_t                  state;
  logic [ACC_W-1:0]        acc;
  logic [LOG2_SAMPLES-1:0] cnt;

  logic                    handshake;
  logic                    accept;
  logic                    last;
  logic [ACC_W-1:0]        acc_sum;
  logic [WIDTH-1:0]        min_next;
  logic [WIDTH-1:0]        max_next;

  // In HOLD a strobe is only usable when the result leaves in the same
  // cycle; acc/cnt/min/max were already cleared at batch close, so it
  // simply becomes sample 0 of the next batch.
  assign handshake = (state == HOLD) && avg_ready;
  assign accept    = count_valid && ((state == ACCUM) || avg_ready);
  // cnt is 0 in HOLD, so a HOLD-accepted sample can never close a batch.
  assign last      = accept && (cnt == {LOG2_SAMPLES{1'b1}});
  assign acc_sum   = acc + {{LOG2_SAMPLES{1'b0}}, count_in};

  min_max_tracker #(
    .WIDTH (WIDTH)
  ) u_min_max (
    .clk      (clk),
    .rst      (rst),
    .clear    (last),
    .sample   (accept),
    .value    (count_in),
    .min_next (min_next),
    .max_next (max_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      avg_out   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (handshake) begin
        avg_valid <= 1'b0;
        state     <= ACCUM;
      end
      if ((state == HOLD) && count_valid && !avg_ready) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        if (last) begin
          // Upper bits of the full sum are the floor of the mean.
          avg_out   <= acc_sum[ACC_W-1:LOG2_SAMPLES];
          min_out   <= min_next;
          max_out   <= max_next;
          avg_valid <= 1'b1;
          state     <= HOLD;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + LOG2_SAMPLES'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ring_count_averager.sv
// Self-checking bench for ring_count_averager (LOG2_SAMPLES=2).
module tb_ring_count_averager;

  localparam int L = 2;
  localparam int N = 1 << L;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] count_in = '0;
  logic         count_valid = 1'b0;
  logic         avg_ready = 1'b0;
  logic [W-1:0] avg_out, min_out, max_out;
  logic         avg_valid, overrun;

  ring_count_averager #(
    .LOG2_SAMPLES (L),
    .WIDTH        (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in    (count_in),
    .count_valid (count_valid),
    .avg_out     (avg_out),
    .min_out     (min_out),
    .max_out     (max_out),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: list of samples in the current batch, a pending flag
  // for an unconsumed result, the last produced result and the sticky flag.
  logic [W-1:0] batch[$];
  bit           m_pending;
  bit           m_ovr;
  logic [W-1:0] m_avg, m_min, m_max;
  int           m_results;

  function automatic void model_reset();
    batch.delete();
    m_pending = 0;
    m_ovr     = 0;
    m_avg     = '0;
    m_min     = '0;
    m_max     = '0;
  endfunction

  function automatic void model_step(bit cv, logic [W-1:0] ci, bit rdy);
    bit take;
    int unsigned sum;
    take = 0;
    if (m_pending) begin
      if (rdy) begin
        m_pending = 0;
        take      = cv;
      end else if (cv) begin
        m_ovr = 1;
      end
    end else begin
      take = cv;
    end
    if (take) begin
      batch.push_back(ci);
      if (batch.size() == N) begin
        sum   = 0;
        m_min = batch[0];
        m_max = batch[0];
        foreach (batch[i]) begin
          sum += batch[i];
          if (batch[i] < m_min) m_min = batch[i];
          if (batch[i] > m_max) m_max = batch[i];
        end
        m_avg = W'(sum / N);
        batch.delete();
        m_pending = 1;
        m_results++;
      end
    end
  endfunction

  task automatic compare_all();
    check("avg_valid", avg_valid, m_pending);
    check("overrun",   overrun,   m_ovr);
    check("avg_out",   avg_out,   m_avg);
    check("min_out",   min_out,   m_min);
    check("max_out",   max_out,   m_max);
  endtask

  task automatic cycle(input bit cv, input logic [W-1:0] ci, input bit rdy);
    count_valid = cv;
    count_in    = ci;
    avg_ready   = rdy;
    @(posedge clk);
    model_step(cv, ci, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    count_valid = 1'b0;
    avg_ready   = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  logic [W-1:0] frz_avg, frz_min, frz_max;
  int base;

  initial begin
    model_reset();
    m_results = 0;
    do_reset();
    check("reset_avg_valid", avg_valid, 0);
    check("reset_overrun",   overrun,   0);

    // Basic mean
    cycle(1, 100, 1); cycle(1, 104, 1); cycle(1, 108, 1); cycle(1, 112, 1);
    check("basic_avg", avg_out, 106);
    check("basic_min", min_out, 100);
    check("basic_max", max_out, 112);
    check("basic_valid_on", avg_valid, 1);
    cycle(0, 0, 1);
    check("basic_valid_1cyc", avg_valid, 0);

    // Truncation and full-scale width
    for (int i = 0; i < N; i++) cycle(1, 16'hFFFF, 1);
    check("fullscale_avg", avg_out, 16'hFFFF);
    cycle(1, 1, 1); cycle(1, 2, 1); cycle(1, 2, 1); cycle(1, 2, 1);
    check("trunc_avg", avg_out, 1);
    check("trunc_min", min_out, 1);
    cycle(0, 0, 1);

    // Back-pressure and overrun
    cycle(1, 300, 0); cycle(1, 320, 0); cycle(1, 340, 0); cycle(1, 360, 0);
    frz_avg = avg_out; frz_min = min_out; frz_max = max_out;
    check("bp_avg", frz_avg, 330);
    cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 60000, 0);
    check("bp_frozen_avg", avg_out, frz_avg);
    check("bp_frozen_min", min_out, frz_min);
    check("bp_frozen_max", max_out, frz_max);
    check("bp_overrun", overrun, 1);
    cycle(0, 0, 1);
    cycle(1, 20, 1); cycle(1, 24, 1); cycle(1, 28, 1); cycle(1, 32, 1);
    check("bp_fresh_avg", avg_out, 26);
    check("bp_fresh_min", min_out, 20);

    // Simultaneous handshake and sample
    do_reset();
    cycle(1, 500, 0); cycle(1, 500, 0); cycle(1, 500, 0); cycle(1, 500, 0);
    cycle(0, 0, 0);
    cycle(1, 50, 1);
    cycle(1, 200, 1); cycle(1, 201, 1); cycle(1, 202, 1);
    check("simul_min", min_out, 50);
    check("simul_avg", avg_out, 163);
    check("simul_overrun", overrun, 0);
    cycle(0, 0, 1);

    // Reset mid-batch
    cycle(1, 900, 1); cycle(1, 800, 1);
    do_reset();
    for (int i = 0; i < N; i++) cycle(1, 10, 1);
    check("rst_avg", avg_out, 10);
    check("rst_min", min_out, 10);
    check("rst_max", max_out, 10);
    check("rst_overrun", overrun, 0);
    cycle(0, 0, 1);

    // Full-rate strobes, 8 batches
    base = m_results;
    for (int i = 0; i < 8 * N; i++) cycle(1, W'($urandom), 1);
    check("fullrate_results", m_results - base, 8);
    check("fullrate_overrun", overrun, 0);
    cycle(0, 0, 1);

    // Random mixed traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      cycle($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ring_count_averager.md
# ring_count_averager

Downstream consumer of the ring-oscillator counting stage. Takes one 16-bit ring count per measurement window and accumulates 2^LOG2_SAMPLES consecutive counts. It then presents the truncated mean, together with the batch minimum and maximum, on a valid/ready output port. This smooths per-window jitter before the result reaches the readout logic and flags any window result lost while the output was stalled.

## Interface
- LOG2_SAMPLES, 4: log2 of samples per batch; legal range 1..8.
- WIDTH, 16: width of the ring count and of all result outputs.
- clk  input  1  system clock; the single clock of the block.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  ring count of a completed window; sampled only when count_valid=1.
- count_valid  input  1  one-cycle strobe from the counting stage, once per window.
- avg_out  output  WIDTH  batch mean, computed as floor(sum / 2^LOG2_SAMPLES).
- min_out  output  WIDTH  smallest sample in the batch.
- max_out  output  WIDTH  largest sample in the batch.
- avg_valid  output  1  result available; held until the handshake completes.
- avg_ready  input  1  consumer accepts the result.
- overrun  output  1  sticky; set when a sample is dropped; cleared only by rst.

## Operation
- States: ACCUM, HOLD.
- Reset, when rst=1 at a clk edge:
  - State goes to ACCUM.
  - acc=0, sample counter=0.
  - Running min = all ones, running max = 0.
  - avg_out, min_out, max_out, avg_valid and overrun all go to 0.
  - Reset mid-batch or in HOLD discards all partial data.
- ACCUM, when count_valid=1:
  - acc += count_in. acc is WIDTH+LOG2_SAMPLES bits wide, so it cannot overflow.
  - Sample counter increments.
  - Running min and max update against count_in.
- Last sample of a batch (counter = 2^LOG2_SAMPLES-1 and count_valid=1):
  - Register the results, with this sample included:
    - avg_out = (acc + count_in) >> LOG2_SAMPLES
    - min_out and max_out = final running min and max
  - Set avg_valid=1 and go to HOLD.
  - Clear acc, the counter and the running min/max for the next batch.
- ACCUM with count_valid=0: all registers hold.
- HOLD:
  - avg_out, min_out, max_out and avg_valid are stable until avg_valid & avg_ready.
  - Handshake: avg_valid drops on the next edge and the state returns to ACCUM.
  - count_valid=1 without the handshake in the same cycle: the sample is dropped and overrun is set.
  - count_valid=1 in the handshake cycle: the sample is accepted as sample 0 of the next batch; overrun is unaffected.
- avg_ready is ignored in ACCUM.
- Counting is unsigned throughout.
- An all-zero batch is legal and produces avg=min=max=0.

## Timing
- count_valid has no back-pressure. The upstream stage issues at most one strobe per clk cycle; back-to-back strobes are legal and are all accepted in ACCUM.
- Latency: avg_valid is high in the cycle after the edge that samples the last count, i.e. 1 cycle.
- Minimum batch period is 2^LOG2_SAMPLES cycles. With avg_ready tied high, there is no loss at full strobe rate: the first sample after the result is taken in the handshake cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The clk/count_in domain is the same domain as the counting stage's system clock. Ring-domain crossing is the counting stage's responsibility.

## Structure
- Shared package ring_meas_pkg holds:
  - the state enum (ACCUM, HOLD);
  - localparam COUNT_W=16;
  - the helper function for the accumulator width (WIDTH+LOG2_SAMPLES).
- One sub-module, min_max_tracker, contains:
  - the running min/max registers;
  - a clear input and a sample strobe;
  - a combinational next-value path, so that the final sample is included at batch close.
- The top level holds the FSM, the accumulator, the sample counter, the result registers and overrun.

## Test plan
- Basic mean: LOG2_SAMPLES=2, samples 100, 104, 108, 112 with avg_ready=1. Require avg_out=106, min_out=100, max_out=112, and avg_valid high for exactly 1 cycle, one cycle after the 4th strobe.
- Truncation and width: LOG2_SAMPLES=2, four samples of 16'hFFFF, then 1, 2, 2, 2. Require avg_out=16'hFFFF with no overflow, then avg_out=1 (7>>2).
- Back-pressure and overrun:
  - Complete a batch with avg_ready=0 and send 3 more strobes. Require the outputs to stay frozen and overrun=1.
  - Raise avg_ready. Require the next batch to start from empty.
- Simultaneous handshake and sample: strobe 50 in the same cycle avg_ready=1 in HOLD. Require the strobe to be counted as sample 0 of the next batch (the next min_out ≤ 50) and overrun to stay 0.
- Reset mid-batch: after 2 of 4 samples, assert rst for 1 cycle, then send 10, 10, 10, 10. Require avg_out=min_out=max_out=10 and overrun=0.
- Continuous full-rate strobes with avg_ready=1 for 8 batches. Require 8 results, all matching a reference model, with no overrun.
